// File: rtl/tx_lane_serializer_pkg.sv
// Shared constants and state encoding for the four-lane TX serializer.
package tx_lane_serializer_pkg;

    localparam logic [7:0]  COM                = 8'hBC;
    localparam logic [7:0]  IDL                = 8'h7C;
    localparam int unsigned SYNC_COUNT_DEFAULT = 4;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/tx_lane_serializer_shift8.sv
// Byte shifter: loads a byte every 8th cycle and shifts it out MSB first.
module tx_shift8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] load_byte_i,
    output logic       load_o,
    output logic       data_o
);

    logic [7:0] sh_q, sh_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    assign load_o = (bit_cnt_q == 3'd0);
    assign data_o = sh_q[7];

    always_comb begin
        sh_d      = load_o ? load_byte_i : {sh_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/tx_lane_serializer.sv
// Four-lane TX serializer: COM sync preamble, then fixed round-robin lane slots.
module tx_lane_serializer
    import tx_lane_serializer_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic       ack0,
    output logic       ack1,
    output logic       ack2,
    output logic       ack3,
    output logic       data_out,
    output logic       active
);

    localparam int unsigned      CNT_W     = (SYNC_COUNT < 1) ? 1 : $clog2(SYNC_COUNT + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COUNT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [1:0]       lane_ptr_q, lane_ptr_d;
    logic             active_q, active_d;

    logic             load;
    logic [7:0]       load_byte;
    logic [7:0]       lane_data [4];
    logic [3:0]       lane_valid;
    logic [3:0]       ack;

    assign lane_data[0] = in0;
    assign lane_data[1] = in1;
    assign lane_data[2] = in2;
    assign lane_data[3] = in3;
    assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

    tx_shift8 u_shift (
        .clk_i       (clk_32f),
        .rst_ni      (reset),
        .load_byte_i (load_byte),
        .load_o      (load),
        .data_o      (data_out)
    );

    // The state flips to ACTIVE one byte early so the next load already serves lane 0;
    // the active flag is separate and only rises on that first lane load.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        lane_ptr_d = lane_ptr_q;
        active_d   = active_q;
        load_byte  = COM;
        ack        = '0;
        case (state_q)
            SYNC: begin
                if (load) begin
                    sync_cnt_d = sync_cnt_q + CNT_W'(1);
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_d    = ACTIVE;
                        lane_ptr_d = '0;
                    end
                end
            end
            ACTIVE: begin
                load_byte = lane_valid[lane_ptr_q] ? lane_data[lane_ptr_q] : IDL;
                if (load) begin
                    ack[lane_ptr_q] = lane_valid[lane_ptr_q];
                    lane_ptr_d      = lane_ptr_q + 2'd1;
                    active_d        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q    <= SYNC;
            sync_cnt_q <= '0;
            lane_ptr_q <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            lane_ptr_q <= lane_ptr_d;
            active_q   <= active_d;
        end
    end

    assign {ack3, ack2, ack1, ack0} = ack;
    assign active = active_q;

endmodule

// File: tb/tb_tx_lane_serializer.sv
// Self-checking bench: slot-arithmetic model, per-cycle compare, serial-byte scoreboard.
module tb_tx_lane_serializer;

    localparam int SC = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lin [4];
    logic [3:0] lv;
    logic [3:0] ack;
    logic       dout;
    logic       act;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    tx_lane_serializer #(.SYNC_COUNT(SC)) dut (
        .clk_32f   (clk),
        .reset     (rst_n),
        .in0       (lin[0]),
        .in1       (lin[1]),
        .in2       (lin[2]),
        .in3       (lin[3]),
        .valid_in0 (lv[0]),
        .valid_in1 (lv[1]),
        .valid_in2 (lv[2]),
        .valid_in3 (lv[3]),
        .ack0      (ack[0]),
        .ack1      (ack[1]),
        .ack2      (ack[2]),
        .ack3      (ack[3]),
        .data_out  (dout),
        .active    (act)
    );

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", name, $time, cyc, got, exp);
        end
    endtask

    // Byte carried by slot k after reset release, decided from the inputs at its load edge.
    function automatic logic [7:0] slot_byte(input int k);
        int ln;
        if (k < SC) return 8'hBC;
        ln = (k - SC) % 4;
        return lv[ln] ? lin[ln] : 8'h7C;
    endfunction

    int         mdl_edges;
    logic [7:0] mdl_byte;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_edges <= 0;
            mdl_byte  <= 8'h00;
        end else begin
            if (mdl_edges % 8 == 0) mdl_byte <= slot_byte(mdl_edges / 8);
            mdl_edges <= mdl_edges + 1;
        end
    end

    int         e, ln;
    logic       exp_do, exp_act;
    logic [3:0] exp_ack;
    logic [7:0] rx;
    bit         pend = 0;
    logic [7:0] pend_b;
    int         pend_end;

    always @(negedge clk) begin
        #1;
        e       = mdl_edges;
        exp_do  = 1'b0;
        exp_act = 1'b0;
        exp_ack = 4'b0000;
        if (rst_n) begin
            if (e > 0) exp_do = mdl_byte[7 - ((e - 1) % 8)];
            exp_act = (e >= 8 * SC + 1);
            if (e % 8 == 0 && e / 8 >= SC) begin
                ln = (e / 8 - SC) % 4;
                exp_ack[ln] = lv[ln];
            end
        end
        check("data_out", 40'(dout), 40'(exp_do));
        check("active", 40'(act), 40'(exp_act));
        check("ack", 40'(ack), 40'(exp_ack));
        check("ack_onehot", 40'($onehot0(ack)), 40'd1);

        if (!rst_n) begin
            pend = 0;
        end else begin
            if (e > 0) rx = {rx[6:0], dout};
            if (pend && e == pend_end) begin
                check("rx_scoreboard", 40'(rx), 40'(pend_b));
                pend = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    pend     = 1;
                    pend_b   = lin[i];
                    pend_end = e + 8;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic get_byte(input int slot, output logic [7:0] b, output logic [3:0] a);
        run_to(8 * slot);
        a = ack;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            b = {b[6:0], dout};
        end
    endtask

    logic [7:0] b;
    logic [3:0] a;
    logic [7:0] ex4 [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lv = 4'b0000;
        for (int i = 0; i < 4; i++) lin[i] = 8'h00;

        // Idle lanes: four COM bytes, then IDL.
        @(negedge clk);
        check("reset_dout", 40'(dout), 40'd0);
        check("reset_active", 40'(act), 40'd0);
        check("reset_ack", 40'(ack), 40'd0);
        do_reset();
        for (int s = 0; s < 4; s++) begin
            get_byte(s, b, a);
            check("sync_com", 40'(b), 40'hBC);
        end
        check("active_pre", 40'(act), 40'd0);
        get_byte(4, b, a);
        check("idle_slot4", 40'(b), 40'h7C);
        check("active_post", 40'(act), 40'd1);
        get_byte(5, b, a);
        check("idle_slot5", 40'(b), 40'h7C);

        // Lane 0 only.
        lin[0] = 8'hA5;
        lv     = 4'b0001;
        do_reset();
        run_to(32);
        check("ack0_first_load", 40'(ack), 40'h1);
        get_byte(4, b, a);
        check("lane0_byte", 40'(b), 40'hA5);
        for (int s = 5; s < 8; s++) begin
            get_byte(s, b, a);
            check("lane123_idle", 40'(b), 40'h7C);
        end
        lv = 4'b0000;
        get_byte(8, b, a);
        check("lane0_dropped", 40'(b), 40'h7C);

        // All lanes valid.
        ex4[0] = 8'h11; ex4[1] = 8'h22; ex4[2] = 8'h33; ex4[3] = 8'h44;
        for (int i = 0; i < 4; i++) lin[i] = ex4[i];
        lv = 4'b1111;
        do_reset();
        for (int s = 4; s < 12; s++) begin
            get_byte(s, b, a);
            check("all_lanes_byte", 40'(b), 40'(ex4[(s - 4) % 4]));
            check("all_lanes_ack", 40'(a), 40'(4'b0001 << ((s - 4) % 4)));
        end

        // Lane 2 valid rising mid-slot.
        lv     = 4'b0010;
        lin    = '{8'h00, 8'h55, 8'h66, 8'h00};
        do_reset();
        get_byte(4, b, a);
        check("l2_slot4_idle", 40'(b), 40'h7C);
        run_to(44);
        lv[2] = 1'b1;
        get_byte(6, b, a);
        check("l2_own_slot", 40'(b), 40'h66);
        check("l2_own_slot_ack", 40'(a), 40'h4);
        run_to(56);
        lv[2]  = 1'b0;
        lin[2] = 8'h99;
        run_to(82);
        lv[2] = 1'b1;
        get_byte(13, b, a);
        check("l1_slot13", 40'(b), 40'h55);
        check("l1_slot13_ack", 40'(a), 40'h2);
        get_byte(14, b, a);
        check("l2_waited", 40'(b), 40'h99);
        check("l2_waited_ack", 40'(a), 40'h4);

        // Reset in the middle of a data byte.
        lv  = 4'b0011;
        lin = '{8'hFF, 8'h22, 8'h00, 8'h00};
        do_reset();
        run_to(37);
        check("midbyte_dout", 40'(dout), 40'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 40'(dout), 40'd0);
        check("async_rst_active", 40'(act), 40'd0);
        check("async_rst_ack", 40'(ack), 40'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int s = 0; s < 4; s++) begin
            get_byte(s, b, a);
            check("resync_com", 40'(b), 40'hBC);
        end
        get_byte(4, b, a);
        check("resync_lane0", 40'(b), 40'hFF);
        check("resync_ack0", 40'(a), 40'h1);
        get_byte(5, b, a);
        check("resync_lane1", 40'(b), 40'h22);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
